// File: rtl/ex_div_ctrl.sv
// EX-stage divider launch/stall/HI-LO write controller with watchdog.
// Optional EX_DIV_ZERO_BYPASS_EN retires a zero divisor without the divider.
module ex_div_ctrl #(
  parameter int TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ABORT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            annul_q, annul_d;
  logic            sgn_q, sgn_d;
  logic [31:0]     op1_q, op1_d;
  logic [31:0]     op2_q, op2_d;
  logic            we_q, we_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            to_q, to_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      annul_q <= 1'b0;
      sgn_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      we_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      annul_q <= annul_d;
      sgn_q   <= sgn_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      we_q    <= we_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    annul_d    = 1'b0;
    sgn_d      = sgn_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    we_d       = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    to_d       = 1'b0;
    stallreq_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (div_req_i && !flush_i) begin
          stallreq_o = 1'b1;
          op1_d      = reg1_i;
          op2_d      = reg2_i;
          sgn_d      = div_signed_i;
          cnt_d      = '0;
`ifdef EX_DIV_ZERO_BYPASS_EN
          if (reg2_i == 32'd0) begin
            hi_d    = reg1_i;
            lo_d    = 32'hFFFF_FFFF;
            we_d    = 1'b1;
            state_d = DONE;
          end else begin
            start_d = 1'b1;
            state_d = BUSY;
          end
`else
          start_d = 1'b1;
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        stallreq_o = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        // Flush wins over a same-cycle ready: the instruction is dead.
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          state_d = IDLE;
        end else if (div_ready_i) begin
          start_d = 1'b0;
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          we_d    = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          to_d    = 1'b1;
          state_d = ABORT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ABORT: begin
        state_d = IDLE;
      end
    endcase
  end

  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = sgn_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hilo_we_o    = we_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign timeout_o    = to_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Bench for ex_div_ctrl: vector table with HI/LO scoreboard plus
// flush, timeout and reset corner sequences against a stub divider.
module tb_ex_div_ctrl;

  logic        clk;
  logic        rst;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        flush_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        stallreq_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        timeout_o;

  ex_div_ctrl #(.TIMEOUT(48)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .div_signed_i (div_signed_i),
    .reg1_i       (reg1_i),
    .reg2_i       (reg2_i),
    .flush_i      (flush_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o),
    .stallreq_o   (stallreq_o),
    .hilo_we_o    (hilo_we_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub divider: ready on start cycle 34 (or 3 for zero divisor).
  logic [7:0] dcnt;
  logic [7:0] dlim;
  logic       tie_low;
  logic signed [31:0] sq, sr;

  always @(posedge clk) begin
    if (!div_start_o) dcnt <= 8'd0;
    else if (dcnt != dlim) dcnt <= dcnt + 8'd1;
  end

  always_comb begin
    dlim = (div_op2_o == 32'd0) ? 8'd2 : 8'd33;
    div_ready_i = div_start_o && (dcnt == dlim) && !tie_low;
    sq = '0;
    sr = '0;
    div_result_i = 64'd0;
    if (div_op2_o != 32'd0) begin
      if (div_signed_o) begin
        sq = $signed(div_op1_o) / $signed(div_op2_o);
        sr = $signed(div_op1_o) % $signed(div_op2_o);
        div_result_i = {sr, sq};
      end else begin
        div_result_i = {div_op1_o % div_op2_o, div_op1_o / div_op2_o};
      end
    end
  end

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    logic        start;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   checks;
  int   failures;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drop_req();
    @(posedge clk);
    #1;
    div_req_i = 1'b0;
    flush_i   = 1'b0;
  endtask

  task automatic do_div(input vec_t v, input int idx);
    int   stalls;
    logic started;
    logic wrote;
    logic done;
    exp_t e;
    @(posedge clk);
    #1;
    div_req_i    = 1'b1;
    div_signed_i = v.sgn;
    reg1_i       = v.a;
    reg2_i       = v.b;
    e.hi = v.hi;
    e.lo = v.lo;
    sb.push_back(e);
    stalls  = 0;
    started = 1'b0;
    wrote   = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (c == 0) chk($sformatf("v%0d_stall_first", idx), 64'(stallreq_o), 64'd1);
      if (div_start_o) started = 1'b1;
      if (hilo_we_o) begin
        wrote = 1'b1;
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", idx), 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_hi", idx), 64'(hi_o), 64'(e.hi));
          chk($sformatf("v%0d_lo", idx), 64'(lo_o), 64'(e.lo));
        end
      end
      if (stallreq_o) stalls++;
      else done = 1'b1;
    end
    chk($sformatf("v%0d_retired", idx), 64'(done), 64'd1);
    chk($sformatf("v%0d_write", idx), 64'(wrote), 64'd1);
    chk($sformatf("v%0d_stalls", idx), 64'(stalls), 64'(v.stalls));
    chk($sformatf("v%0d_start", idx), 64'(started), 64'(v.start));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] ph, pl;
    int          n;
    logic        seen;

    checks   = 0;
    failures = 0;
    tie_low  = 1'b0;

    vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd2, 32'h0000000E, 35, 1'b1};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35, 1'b1};
    vecs[2] = '{1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 35, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 35, 1'b1};
`ifdef EX_DIV_ZERO_BYPASS_EN
    vecs[4] = '{1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 1'b0};
`else
    vecs[4] = '{1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 4, 1'b1};
`endif
    vecs[5] = '{1'b0, 32'd20, 32'd3, 32'd2, 32'd6, 35, 1'b1};
    vecs[6] = '{1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 35, 1'b1};

    rst          = 1'b1;
    div_req_i    = 1'b0;
    div_signed_i = 1'b0;
    reg1_i       = '0;
    reg2_i       = '0;
    flush_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({div_start_o, div_annul_o, div_signed_o, stallreq_o,
                         hilo_we_o, timeout_o}), 64'd0);
    chk("rst_ops", {div_op1_o, div_op2_o}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_div(vecs[i], i);
      if (i != 5) drop_req();
    end

    // Request together with flush in IDLE is ignored.
    @(posedge clk);
    #1;
    div_req_i = 1'b1;
    reg1_i    = 32'd50;
    reg2_i    = 32'd5;
    flush_i   = 1'b1;
    @(negedge clk);
    chk("flush_accept_stall", 64'(stallreq_o), 64'd0);
    drop_req();
    @(negedge clk);
    chk("flush_accept_start", 64'(div_start_o), 64'd0);

    // Flush on the 10th BUSY cycle.
    ph = hi_o;
    pl = lo_o;
    @(posedge clk);
    #1;
    div_req_i = 1'b1;
    reg1_i    = 32'd1000;
    reg2_i    = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall", 64'(stallreq_o), 64'd1);
    chk("flush_busy_start", 64'(div_start_o), 64'd1);
    @(posedge clk);
    #1;
    flush_i   = 1'b0;
    div_req_i = 1'b0;
    @(negedge clk);
    chk("flush_annul", 64'(div_annul_o), 64'd1);
    chk("flush_stall_after", 64'(stallreq_o), 64'd0);
    chk("flush_start_drop", 64'(div_start_o), 64'd0);
    chk("flush_we", 64'(hilo_we_o), 64'd0);
    chk("flush_hilo_kept", {hi_o, lo_o}, {ph, pl});
    seen = 1'b0;
    n    = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hilo_we_o) seen = 1'b1;
      if (div_annul_o) n++;
    end
    chk("flush_no_write", 64'(seen), 64'd0);
    chk("flush_annul_once", 64'(n), 64'd0);

    // Watchdog with the divider never finishing.
    tie_low = 1'b1;
    @(posedge clk);
    #1;
    div_req_i = 1'b1;
    reg1_i    = 32'd50;
    reg2_i    = 32'd5;
    n         = 0;
    seen      = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (timeout_o) seen = 1'b1;
      else if (div_start_o) n++;
    end
    chk("to_fired", 64'(seen), 64'd1);
    chk("to_busy_cycles", 64'(n), 64'd48);
    chk("to_pulses", 64'({timeout_o, div_annul_o}), 64'd3);
    chk("to_abort_outs", 64'({stallreq_o, hilo_we_o, div_start_o}), 64'd0);
    drop_req();
    @(negedge clk);
    chk("to_pulse_end", 64'({timeout_o, div_annul_o}), 64'd0);
    tie_low = 1'b0;

    // Reset in the middle of a divide.
    @(posedge clk);
    #1;
    div_req_i = 1'b1;
    reg1_i    = 32'd77;
    reg2_i    = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst       = 1'b1;
    div_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ctrl", 64'({div_start_o, div_annul_o, div_signed_o, stallreq_o,
                             hilo_we_o, timeout_o}), 64'd0);
    chk("mid_rst_hilo", {hi_o, lo_o}, 64'd0);
    do_div(vecs[6], 7);
    drop_req();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
